// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES DMA sequencer: FSM states, mode codes and
// block geometry.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_AES = 3'd3,
    ST_STORE    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [1:0] MODE_ENC = 2'b01;
  localparam logic [1:0] MODE_DEC = 2'b10;

  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = 4;

  // Only the two defined mode codes start a job; 00 and 11 are rejected.
  function automatic logic mode_legal(input logic [1:0] mode);
    return (mode == MODE_ENC) || (mode == MODE_DEC);
  endfunction

endpackage

// File: rtl/aes_word_buf.sv
// 128-bit block buffer: 32-bit shift-in from memory reads (first word ends up
// in [127:96]), parallel load of the core result, and word select for stores.
module aes_word_buf
  import aes_ctrl_pkg::*;
(
  input  logic         hclk,
  input  logic         hreset,
  input  logic         shift_en,
  input  logic [31:0]  shift_word,
  input  logic         load_en,
  input  logic [127:0] load_data,
  input  logic [1:0]   sel,
  output logic [127:0] data,
  output logic [31:0]  word
);

  logic [127:0] blk_d;
  logic [127:0] blk_q;

  // Next buffer contents: a core result overrides a memory shift.
  always_comb begin
    blk_d = blk_q;
    if (load_en) begin
      blk_d = load_data;
    end else if (shift_en) begin
      blk_d = {blk_q[95:0], shift_word};
    end
  end

  // Buffer register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      blk_q <= '0;
    end else begin
      blk_q <= blk_d;
    end
  end

  // Word 0 is the most significant word, matching the order it was fetched.
  always_comb begin
    case (sel)
      2'd0:    word = blk_q[127:96];
      2'd1:    word = blk_q[95:64];
      2'd2:    word = blk_q[63:32];
      default: word = blk_q[31:0];
    endcase
  end

  assign data = blk_q;

endmodule

// File: rtl/aes_dma_ctrl.sv
// AES DMA sequencer: latches a job on cfg_start, then per 128-bit block reads
// four words, runs the AES core, and writes four result words back.
module aes_dma_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         hclk,
  input  logic         hreset,
  input  logic         cfg_start,
  input  logic [31:0]  cfg_src,
  input  logic [31:0]  cfg_dst,
  input  logic [127:0] cfg_key,
  input  logic [1:0]   cfg_mode,
  input  logic [31:0]  cfg_size,
  output logic         mem_req,
  output logic         mem_write,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         aes_start,
  output logic         aes_mode,
  output logic [127:0] aes_key,
  output logic [127:0] aes_din,
  input  logic         aes_done,
  input  logic [127:0] aes_dout,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [1:0]  LAST_WORD    = 2'(WORDS_PER_BLOCK - 1);
  localparam logic [31:0] BLOCK_STEP   = 32'(BLOCK_BYTES);

  state_e        state_d,   state_q;
  logic [31:0]   src_d,     src_q;
  logic [31:0]   dst_d,     dst_q;
  logic [127:0]  key_d,     key_q;
  logic [1:0]    mode_d,    mode_q;
  logic [27:0]   blk_cnt_d, blk_cnt_q;
  logic [1:0]    idx_d,     idx_q;
  logic [31:0]   wait_cnt_d, wait_cnt_q;
  logic          err_d,     err_q;

  logic          buf_shift;
  logic          buf_load;
  logic [127:0]  buf_data;
  logic [31:0]   buf_word;
  logic [31:0]   xfer_base;

  aes_word_buf u_buf (
    .hclk       (hclk),
    .hreset     (hreset),
    .shift_en   (buf_shift),
    .shift_word (mem_rdata),
    .load_en    (buf_load),
    .load_data  (aes_dout),
    .sel        (idx_q),
    .data       (buf_data),
    .word       (buf_word)
  );

  // Sequencer next-state and shadow-register update.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    key_d      = key_q;
    mode_d     = mode_q;
    blk_cnt_d  = blk_cnt_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    buf_shift  = 1'b0;
    buf_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          src_d     = cfg_src;
          dst_d     = cfg_dst;
          key_d     = cfg_key;
          mode_d    = cfg_mode;
          blk_cnt_d = cfg_size[31:4];
          idx_d     = 2'd0;
          err_d     = 1'b0;
          if (!mode_legal(cfg_mode) || (cfg_size[3:0] != 4'd0)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (cfg_size == 32'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (mem_ack) begin
          buf_shift = 1'b1;
          idx_d     = idx_q + 2'd1;
          if (idx_q == LAST_WORD) begin
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        wait_cnt_d = 32'd0;
        state_d    = ST_WAIT_AES;
      end

      ST_WAIT_AES: begin
        // A result in the final allowed cycle still wins over the timeout.
        if (aes_done) begin
          buf_load = 1'b1;
          idx_d    = 2'd0;
          state_d  = ST_STORE;
        end else if (wait_cnt_q >= TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end

      ST_STORE: begin
        if (mem_ack) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == LAST_WORD) begin
            src_d     = src_q + BLOCK_STEP;
            dst_d     = dst_q + BLOCK_STEP;
            blk_cnt_d = blk_cnt_q - 28'd1;
            state_d   = (blk_cnt_q == 28'd1) ? ST_DONE : ST_LOAD;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and shadow registers; reset aborts any job in flight.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      key_q      <= '0;
      mode_q     <= '0;
      blk_cnt_q  <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      key_q      <= key_d;
      mode_q     <= mode_d;
      blk_cnt_q  <= blk_cnt_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Outputs decode straight from registered state so they hold across stalls
  // and drop to zero the moment reset hits.
  always_comb begin
    mem_req   = (state_q == ST_LOAD) || (state_q == ST_STORE);
    mem_write = (state_q == ST_STORE);
    xfer_base = (state_q == ST_STORE) ? dst_q : src_q;
    mem_addr  = mem_req ? (xfer_base + {28'd0, idx_q, 2'b00}) : 32'd0;
    mem_wdata = mem_write ? buf_word : 32'd0;
    aes_start = (state_q == ST_START);
    aes_mode  = (mode_q == MODE_DEC);
    aes_key   = key_q;
    aes_din   = buf_data;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    err       = err_q;
  end

endmodule

// File: tb/tb_aes_dma_ctrl.sv
// Randomized bench for aes_dma_ctrl: memory and AES-core models plus a
// transaction-level reference of the expected bus traffic per job.
`timescale 1ns/1ps
module tb_aes_dma_ctrl;

  logic         hclk = 1'b0;
  logic         hreset;
  logic         cfg_start;
  logic [31:0]  cfg_src, cfg_dst, cfg_size;
  logic [127:0] cfg_key;
  logic [1:0]   cfg_mode;
  logic         mem_req, mem_write, mem_ack;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         aes_start, aes_mode, aes_done;
  logic [127:0] aes_key, aes_din, aes_dout;
  logic         busy, done, err;

  always #5 hclk = ~hclk;

  aes_dma_ctrl #(.TIMEOUT_CYC(8)) dut (
    .hclk(hclk), .hreset(hreset), .cfg_start(cfg_start), .cfg_src(cfg_src),
    .cfg_dst(cfg_dst), .cfg_key(cfg_key), .cfg_mode(cfg_mode), .cfg_size(cfg_size),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .aes_start(aes_start), .aes_mode(aes_mode), .aes_key(aes_key),
    .aes_din(aes_din), .aes_done(aes_done), .aes_dout(aes_dout),
    .busy(busy), .done(done), .err(err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory contents are a fixed function of the address.
  logic [31:0] mem_seed = 32'h1234_5678;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction
  assign mem_rdata = (mem_addr * 32'h9E37_79B1) ^ mem_seed;

  typedef struct packed { logic w; logic [31:0] a; logic [31:0] d; } xact_t;
  xact_t act_q[$];

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  int          ack_mode = 0;
  int          stall_left = 0;
  logic [31:0] stall_addr = 32'h0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          req_cycles = 0;
  logic        pend = 1'b0;
  logic [65:0] pend_v = '0;

  // Memory slave: chooses mem_ack for the current cycle, records accepted
  // transfers, and checks that a stalled request is held unchanged.
  always @(negedge hclk) begin : mem_slave
    logic a;
    if (hreset) begin
      pend    = 1'b0;
      mem_ack = 1'b0;
    end else begin
      a = (ack_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mem_req && !mem_write && rd_cnt == 1 && stall_left > 0) begin
        a = 1'b0;
        stall_left--;
        chk("stall_addr", 128'(mem_addr), 128'(stall_addr));
      end
      mem_ack = a;
      if (pend) chk("hold_req", 128'({mem_req, mem_write, mem_addr, mem_wdata}), 128'(pend_v));
      if (mem_req) req_cycles++;
      if (mem_req && a) begin
        act_q.push_back({mem_write, mem_addr, mem_write ? mem_wdata : 32'h0});
        if (!mem_write) rd_cnt++;
      end
      pend   = mem_req && !a;
      pend_v = {mem_req, mem_write, mem_addr, mem_wdata};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  int           aes_lat = 1;
  logic         core_en = 1'b1;
  logic         spur_done = 1'b0;
  logic         exp_mode_dec = 1'b0;
  int           aes_dly = 0;
  logic         aes_armed = 1'b0;
  logic [127:0] aes_hold = '0;
  int           aes_starts = 0;

  // AES core model: dout = din ^ key, aes_lat cycles after aes_start.
  always @(negedge hclk) begin : aes_core
    aes_done = 1'b0;
    if (hreset) begin
      aes_armed = 1'b0;
    end else if (aes_start) begin
      aes_starts++;
      if (spur_done) begin
        aes_done = 1'b1;
        aes_dout = {4{32'hDEAD_BEEF}};
      end
      if (core_en) begin
        aes_armed = 1'b1;
        aes_dly   = aes_lat;
        aes_hold  = aes_din;
      end
    end else if (aes_armed) begin
      if (aes_dly <= 1) begin
        chk("aes_din_hold", aes_din, aes_hold);
        chk("aes_mode", 128'(aes_mode), 128'(exp_mode_dec));
        aes_dout  = aes_din ^ aes_key;
        aes_done  = 1'b1;
        aes_armed = 1'b0;
      end else begin
        aes_dly--;
      end
    end
  end

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] size, input logic [1:0] mode,
                         input logic [127:0] key, input int ackm, input int lat,
                         input bit cen, input bit inj, input bit chk_lat);
    xact_t        exp_q[$];
    int           n, guard, t0, s0, exp_lat;
    bit           legal, exp_err, injected;
    logic [127:0] blk;
    logic [31:0]  a;
    legal   = ((mode == 2'b01) || (mode == 2'b10)) && (size[3:0] == 4'd0);
    exp_err = !legal;
    n       = 0;
    if (legal && size != 32'd0) begin
      n = int'(size >> 4);
      for (int b = 0; b < n; b++) begin
        blk = '0;
        for (int i = 0; i < 4; i++) begin
          a = src + 32'(16 * b + 4 * i);
          exp_q.push_back({1'b0, a, 32'h0});
          blk = {blk[95:0], word_at(a)};
        end
        if (!cen) begin
          exp_err = 1'b1;
          break;
        end
        blk = blk ^ key;
        for (int i = 0; i < 4; i++)
          exp_q.push_back({1'b1, dst + 32'(16 * b + 4 * i), blk[127 - 32 * i -: 32]});
      end
    end
    exp_lat = (n > 0) ? 10 * n + 1 : 1;

    ack_mode = ackm; aes_lat = lat; core_en = cen;
    exp_mode_dec = (mode == 2'b10);
    act_q.delete(); rd_cnt = 0; done_cnt = 0; req_cycles = 0;
    s0 = aes_starts;
    @(negedge hclk);
    cfg_src = src; cfg_dst = dst; cfg_size = size; cfg_mode = mode; cfg_key = key;
    cfg_start = 1'b1;
    t0 = cyc;
    @(negedge hclk);
    cfg_start = 1'b0;
    chk("busy_n1", 128'(busy), 128'(1));
    chk("err_n1", 128'(err), 128'(!legal));

    guard = 0; injected = 1'b0;
    while (done_cnt == 0 && guard < 100 * n + 100) begin
      @(negedge hclk);
      guard++;
      if (inj && !injected && aes_starts > s0) begin
        injected = 1'b1;
        @(negedge hclk);
        cfg_src = ~src; cfg_dst = ~dst; cfg_size = 32'h40; cfg_mode = 2'b11;
        cfg_key = ~key; cfg_start = 1'b1;
        @(negedge hclk);
        cfg_start = 1'b0;
        guard += 2;
      end
    end
    chk("done_seen", 128'(done_cnt != 0), 128'(1));
    if (chk_lat && done_cnt != 0) chk("done_lat", 128'(done_cyc - t0), 128'(exp_lat));
    repeat (4) @(negedge hclk);
    chk("done_once", 128'(done_cnt), 128'(1));
    chk("err_final", 128'(err), 128'(exp_err));
    chk("busy_idle", 128'(busy), 128'(0));
    chk("xact_count", 128'(act_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("xact%0d", i), 128'(act_q[i]), 128'(exp_q[i]));
    if (exp_q.size() == 0) chk("no_req", 128'(req_cycles), 128'(0));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem"}, 128'({mem_req, mem_write, mem_addr, mem_wdata}), 128'(0));
    chk({tag, "_key"}, aes_key, 128'(0));
    chk({tag, "_din"}, aes_din, 128'(0));
    chk({tag, "_stat"}, 128'({aes_start, aes_mode, busy, done, err}), 128'(0));
  endtask

  initial begin
    int g, t0;
    logic [31:0] r_src, r_dst;
    logic [127:0] r_key;
    hreset = 1'b1; cfg_start = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_size = '0;
    cfg_key = '0; cfg_mode = '0; mem_ack = 1'b0; aes_done = 1'b0; aes_dout = '0;
    repeat (2) @(negedge hclk);
    chk_outputs_zero("reset");
    hreset = 1'b0;
    @(negedge hclk);

    // Two-block encrypt with ideal memory and 1-cycle core.
    r_key = {$urandom, $urandom, $urandom, $urandom};
    run_job(32'h100, 32'h200, 32'd32, 2'b01, r_key, 0, 1, 1'b1, 1'b0, 1'b1);
    // Degenerate starts, then a legal start that clears err.
    run_job(32'h100, 32'h200, 32'd0, 2'b01, r_key, 0, 1, 1'b1, 1'b0, 1'b1);
    run_job(32'h100, 32'h200, 32'd20, 2'b01, r_key, 0, 1, 1'b1, 1'b0, 1'b1);
    run_job(32'h100, 32'h200, 32'd16, 2'b11, r_key, 0, 1, 1'b1, 1'b0, 1'b1);
    run_job(32'h300, 32'h400, 32'd16, 2'b10, r_key, 0, 1, 1'b1, 1'b0, 1'b1);
    // Second read stalled for three cycles.
    stall_left = 3; stall_addr = 32'h104;
    run_job(32'h100, 32'h200, 32'd16, 2'b01, r_key, 0, 1, 1'b1, 1'b0, 1'b0);
    chk("stall_used", 128'(stall_left), 128'(0));
    // cfg_start during WAIT_AES is ignored.
    run_job(32'h500, 32'h600, 32'd32, 2'b01, r_key, 0, 3, 1'b1, 1'b1, 1'b0);
    // Core never answers.
    run_job(32'h700, 32'h800, 32'd32, 2'b01, r_key, 0, 1, 1'b0, 1'b0, 1'b0);
    // aes_done in the START cycle is ignored.
    spur_done = 1'b1;
    run_job(32'h900, 32'hA00, 32'd16, 2'b01, r_key, 0, 1, 1'b1, 1'b0, 1'b1);
    spur_done = 1'b0;

    // Reset during STORE word 2, then a fresh 16-byte job.
    ack_mode = 0; aes_lat = 1; core_en = 1'b1;
    @(negedge hclk);
    cfg_src = 32'h100; cfg_dst = 32'h200; cfg_size = 32'd32; cfg_mode = 2'b01;
    cfg_key = r_key; cfg_start = 1'b1;
    t0 = cyc;
    @(negedge hclk);
    cfg_start = 1'b0;
    g = 0;
    while (cyc != t0 + 8 && g < 50) begin
      @(negedge hclk);
      g++;
    end
    chk("pre_rst_store", 128'({mem_req, mem_write, mem_addr}), 128'({2'b11, 32'h204}));
    hreset = 1'b1;
    #1;
    chk_outputs_zero("async_rst");
    done_cnt = 0; req_cycles = 0;
    @(negedge hclk);
    hreset = 1'b0;
    repeat (3) @(negedge hclk);
    chk("rst_no_done", 128'(done_cnt), 128'(0));
    chk("rst_no_req", 128'(req_cycles), 128'(0));
    run_job(32'h100, 32'h200, 32'd16, 2'b01, r_key, 0, 1, 1'b1, 1'b0, 1'b1);

    // Randomized jobs: random ack stalls, core latency, addresses, key, mode.
    for (int it = 0; it < 12; it++) begin
      mem_seed = $urandom;
      r_src = $urandom; r_src[1:0] = 2'b00;
      r_dst = $urandom; r_dst[1:0] = 2'b00;
      if (it == 0) r_src = 32'hFFFF_FFF0;
      if (it == 1) r_dst = 32'hFFFF_FFE8;
      r_key = {$urandom, $urandom, $urandom, $urandom};
      spur_done = 1'($urandom_range(0, 1));
      run_job(r_src, r_dst, 32'(16 * $urandom_range(1, 4)),
              ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, r_key,
              1, int'($urandom_range(1, 6)), 1'b1, 1'b0, 1'b0);
    end
    spur_done = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
